// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the RAM data-port arbiter.
// Holds the FSM, owner and operation encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    localparam int DEFAULT_HOST_BURST_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the RAM data port between CPU and host.
// Host-priority request/ack FSM with an anti-starvation streak counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int HOST_BURST_MAX = DEFAULT_HOST_BURST_MAX
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req_rd,
    input  logic              cpu_req_wr,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req_rd,
    input  logic              host_req_wr,
    input  logic [31:0]       host_addr,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata
);

    localparam int SW = $clog2(HOST_BURST_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(HOST_BURST_MAX);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [31:0]       cpu_rdata_q, host_rdata_q;

    logic cpu_pend, host_pend, grant_host;
    logic in_access, in_resp, cpu_rd_live, host_rd_live;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], host_addr[31:ADDR_W]};

    assign cpu_pend  = cpu_req_rd | cpu_req_wr;
    assign host_pend = host_req_rd | host_req_wr;
    // Host wins ties until it has taken HOST_BURST_MAX grants in a row over a waiting CPU.
    assign grant_host = host_pend & (~cpu_pend | (streak_q != STREAK_MAX));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_pend | host_pend) begin
                    state_d = ACCESS;
                    if (grant_host) begin
                        owner_d = OWN_HOST;
                        op_d    = host_req_wr ? OP_WR : OP_RD;
                        addr_d  = host_addr[ADDR_W-1:0];
                        wdata_d = host_wdata;
                        if (!cpu_pend)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + SW'(1);
                    end else begin
                        owner_d  = OWN_CPU;
                        op_d     = cpu_req_wr ? OP_WR : OP_RD;
                        addr_d   = cpu_addr[ADDR_W-1:0];
                        wdata_d  = cpu_wdata;
                        streak_d = '0;
                    end
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            streak_q     <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            if (cpu_rd_live)
                cpu_rdata_q <= ram_rdata;
            if (host_rd_live)
                host_rdata_q <= ram_rdata;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign ram_we    = in_access & (op_q == OP_WR);
    assign ram_re    = in_access & (op_q == OP_RD);
    assign ram_addr  = in_access ? addr_q : '0;
    assign ram_wdata = in_access ? wdata_q : '0;

    assign cpu_ack  = in_resp & (owner_q == OWN_CPU);
    assign host_ack = in_resp & (owner_q == OWN_HOST);

    // RAM data arrives during RESP, so it is forwarded in the ack cycle and held afterwards.
    assign cpu_rd_live  = cpu_ack & (op_q == OP_RD);
    assign host_rd_live = host_ack & (op_q == OP_RD);
    assign cpu_rdata    = cpu_rd_live ? ram_rdata : cpu_rdata_q;
    assign host_rdata   = host_rd_live ? ram_rdata : host_rdata_q;

    assign cpu_stall = cpu_pend & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// A small behavioural RAM answers the data port one cycle after ram_re.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cpu_req_rd, cpu_req_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        host_req_rd, host_req_wr;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        host_ack;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we, ram_re;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    mem_port_arbiter #(.ADDR_W(12), .HOST_BURST_MAX(4)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req_rd(cpu_req_rd), .cpu_req_wr(cpu_req_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .host_req_rd(host_req_rd), .host_req_wr(host_req_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        cpu_req_rd = 0; cpu_req_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req_rd = 0; host_req_wr = 0; host_addr = 0; host_wdata = 0;
        ram_rdata = 0;
        tick(); tick();

        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_acks", {cpu_ack, host_ack}, 0);
        chk("rst_ram_ctl", {ram_we, ram_re}, 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_stall", cpu_stall, 0);
        nrst = 1'b1;
        tick();
        chk("idle_ram_ctl", {ram_we, ram_re}, 0);

        // CPU write 0xDEADBEEF to 0x010
        cpu_req_wr = 1; cpu_addr = 32'h010; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("cw_T_stall", cpu_stall, 1);
        chk("cw_T_we", ram_we, 0);
        tick();
        chk("cw_T1_ctl", {ram_we, ram_re}, 2'b10);
        chk("cw_T1_addr", 32'(ram_addr), 32'h010);
        chk("cw_T1_wdata", ram_wdata, 32'hDEADBEEF);
        chk("cw_T1_stall", cpu_stall, 1);
        chk("cw_T1_ack", cpu_ack, 0);
        tick();
        chk("cw_T2_ack", {cpu_ack, host_ack}, 2'b10);
        chk("cw_T2_stall", cpu_stall, 0);
        cpu_req_wr = 0;
        tick();
        chk("cw_T3_ctl", {ram_we, ram_re, cpu_ack}, 0);

        // CPU read of 0x010
        cpu_req_rd = 1; cpu_addr = 32'h010;
        tick();
        chk("cr_T1_ctl", {ram_we, ram_re}, 2'b01);
        tick();
        chk("cr_T2_ack", cpu_ack, 1);
        chk("cr_T2_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req_rd = 0;
        tick();
        chk("cr_hold_rdata", cpu_rdata, 32'hDEADBEEF);

        // simultaneous requests, streak 0: host first
        cpu_req_rd = 1; cpu_addr = 32'h010;
        host_req_wr = 1; host_addr = 32'h030; host_wdata = 32'h77;
        #1;
        chk("both_T_stall", cpu_stall, 1);
        tick();
        chk("both_T1_ctl", {ram_we, ram_re}, 2'b10);
        chk("both_T1_addr", 32'(ram_addr), 32'h030);
        tick();
        chk("both_T2_acks", {cpu_ack, host_ack}, 2'b01);
        chk("both_T2_stall", cpu_stall, 1);
        host_req_wr = 0;
        tick();
        chk("both_T3", {cpu_ack, host_ack, cpu_stall}, 3'b001);
        tick();
        chk("both_T4_ctl", {ram_we, ram_re}, 2'b01);
        chk("both_T4_addr", 32'(ram_addr), 32'h010);
        chk("both_T4_stall", cpu_stall, 1);
        tick();
        chk("both_T5_acks", {cpu_ack, host_ack}, 2'b10);
        chk("both_T5_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("both_T5_stall", cpu_stall, 0);
        cpu_req_rd = 0;
        tick();

        // host streams, CPU waits: H H H H C H
        host_req_rd = 1; host_addr = 32'h030;
        cpu_req_rd = 1; cpu_addr = 32'h010;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("burst%0d_ctl", g), {ram_we, ram_re}, 2'b01);
            tick();
            if (g == 4) begin
                chk("burst_cpu_ack", {cpu_ack, host_ack}, 2'b10);
                chk("burst_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
                chk("burst_streak_clr", 32'(dut.streak_q), 0);
            end else begin
                chk($sformatf("burst%0d_host_ack", g), {cpu_ack, host_ack}, 2'b01);
                chk($sformatf("burst%0d_rdata", g), host_rdata, 32'h77);
                chk($sformatf("burst%0d_stall", g), cpu_stall, 1);
            end
            tick();
        end
        host_req_rd = 0; cpu_req_rd = 0;
        tick(); tick(); tick();

        // host rd+wr together is a write
        host_req_rd = 1; host_req_wr = 1; host_addr = 32'h020; host_wdata = 32'h5;
        tick();
        chk("hrw_ctl", {ram_we, ram_re}, 2'b10);
        chk("hrw_addr", 32'(ram_addr), 32'h020);
        tick();
        chk("hrw_ack", host_ack, 1);
        chk("hrw_rdata_hold", host_rdata, 32'h77);
        host_req_rd = 0; host_req_wr = 0;
        tick();
        host_req_rd = 1;
        tick();
        chk("hr_ctl", {ram_we, ram_re}, 2'b01);
        tick();
        chk("hr_rdata", host_rdata, 32'h5);
        host_req_rd = 0;
        tick();

        // address truncation and request change during ACCESS
        cpu_req_wr = 1; cpu_addr = 32'hFFFF_F123; cpu_wdata = 32'hA5A5;
        tick();
        chk("tr_addr", 32'(ram_addr), 32'h123);
        chk("tr_ctl", {ram_we, ram_re}, 2'b10);
        cpu_req_wr = 0; cpu_req_rd = 1; cpu_addr = 32'h010; cpu_wdata = 32'h1111;
        tick();
        chk("tr_ack", cpu_ack, 1);
        chk("tr_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        cpu_req_rd = 0;
        tick();
        cpu_req_rd = 1; cpu_addr = 32'h123;
        tick(); tick();
        chk("tr_readback", cpu_rdata, 32'hA5A5);
        cpu_req_rd = 0;
        tick();

        // reset mid-ACCESS
        cpu_req_wr = 1; cpu_addr = 32'h040; cpu_wdata = 32'h99;
        tick();
        chk("rm_we_pre", ram_we, 1);
        nrst = 1'b0;
        #1;
        chk("rm_we_now", {ram_we, ram_re}, 0);
        chk("rm_ram_addr", 32'(ram_addr), 0);
        chk("rm_rdata", {cpu_rdata, host_rdata}, 0);
        cpu_req_wr = 0;
        tick();
        chk("rm_no_ack", {cpu_ack, host_ack}, 0);
        nrst = 1'b1;
        tick();
        chk("rm_state", 32'(dut.state_q), 32'(IDLE));
        chk("rm_no_ack2", {cpu_ack, host_ack}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
